// File: rtl/dbg_loader_pkg.sv
// Shared definitions for the debug memory loader: command opcodes, FSM
// state type, default response bytes and small opcode decode helpers.
package dbg_loader_pkg;

  localparam logic [7:0] OP_WR_I = 8'h01;
  localparam logic [7:0] OP_WR_D = 8'h02;
  localparam logic [7:0] OP_RD_I = 8'h03;
  localparam logic [7:0] OP_RD_D = 8'h04;
  localparam logic [7:0] OP_RUN  = 8'h05;
  localparam logic [7:0] OP_HALT = 8'h06;

  localparam logic [7:0] ACK_DEFAULT = 8'hAA;
  localparam logic [7:0] ERR_DEFAULT = 8'hEE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_EXEC,
    ST_RD_WAIT,
    ST_CTRL,
    ST_RESP
  } state_e;

  function automatic logic op_is_write(input logic [7:0] op);
    return (op == OP_WR_I) || (op == OP_WR_D);
  endfunction

  function automatic logic op_is_icache(input logic [7:0] op);
    return (op == OP_WR_I) || (op == OP_RD_I);
  endfunction

endpackage

// File: rtl/byte_shift_le.sv
// 4-byte little-endian assemble/serialise register.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   clr_i           restart the byte index (word contents kept)
//   load_i          parallel load word_i, index back to 0
//   shift_i         shift one byte: byte_i enters at the top, word moves
//                   down by 8 bits, index advances
//   byte_i, word_i  serial / parallel inputs
//   word_o          assembled word (byte k of a 4-byte run ends in [8k+7:8k])
//   byte_o          current byte to serialise (word_o[7:0])
//   last_o          index is 3, i.e. the next shift completes a 4-byte run
module byte_shift_le (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clr_i,
  input  logic        load_i,
  input  logic        shift_i,
  input  logic [7:0]  byte_i,
  input  logic [31:0] word_i,
  output logic [31:0] word_o,
  output logic [7:0]  byte_o,
  output logic        last_o
);

  logic [31:0] word_q, word_d;
  logic [1:0]  idx_q, idx_d;

  // A right shift serves both directions: assembling places the first byte
  // in the LSB after four shifts, and serialising emits the LSB first.
  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    if (clr_i) begin
      idx_d = '0;
    end else if (load_i) begin
      word_d = word_i;
      idx_d  = '0;
    end else if (shift_i) begin
      word_d = {byte_i, word_q[31:8]};
      idx_d  = idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_q <= '0;
      idx_q  <= '0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
    end
  end

  assign word_o = word_q;
  assign byte_o = word_q[7:0];
  assign last_o = (idx_q == 2'd3);

endmodule

// File: rtl/dbg_mem_loader.sv
// Host-side initiator for the core's instruction/data cache debug ports.
// Decodes a byte-stream command protocol, performs word writes/reads on the
// A2/WD2/WE2/RD2 debug ports, returns read data or status bytes, and owns
// the core reset (held after power-up).
// Ports:
//   clk, rst_n                  clock (shared with the core), async active-low reset
//   rx_data/rx_valid/rx_ready   inbound command bytes
//   tx_data/tx_valid/tx_ready   outbound response bytes
//   dbg_i_*                     instruction-cache debug port
//   dbg_d_*                     data-cache debug port
//   cpu_rst                     active-high reset to the core
//   busy                        a command is in progress
module dbg_mem_loader
  import dbg_loader_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 1,
  parameter logic [7:0]  ACK_BYTE     = ACK_DEFAULT,
  parameter logic [7:0]  ERR_BYTE     = ERR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] dbg_i_a2,
  output logic [31:0] dbg_i_wd2,
  output logic [3:0]  dbg_i_we2,
  input  logic [31:0] dbg_i_rd2,
  output logic [31:0] dbg_d_a2,
  output logic [31:0] dbg_d_wd2,
  output logic [3:0]  dbg_d_we2,
  input  logic [31:0] dbg_d_rd2,
  output logic        cpu_rst,
  output logic        busy
);

  localparam logic [1:0] RL_LAST = 2'(READ_LATENCY);

  state_e      state_q, state_d;
  logic [7:0]  op_q, op_d;
  logic [7:0]  resp_byte_q, resp_byte_d;
  logic        resp_multi_q, resp_multi_d;
  logic        cpu_rst_q, cpu_rst_d;
  logic [1:0]  wait_q, wait_d;
  logic [31:0] i_a2_q, i_a2_d, i_wd2_q, i_wd2_d;
  logic [31:0] d_a2_q, d_a2_d, d_wd2_q, d_wd2_d;

  logic        rx_fire, tx_fire;
  logic        rx_clr, addr_shift, data_shift, tx_load, tx_adv;
  logic        sel_i, port_active, exec_active;
  logic [31:0] addr_word, data_word, tx_word_in;
  logic        addr_last, data_last, tx_last;
  logic [7:0]  tx_byte;
  logic [7:0]  unused_addr_byte, unused_data_byte;
  logic [31:0] unused_tx_word;

  assign rx_ready    = (state_q == ST_IDLE) || (state_q == ST_ADDR) || (state_q == ST_DATA);
  assign tx_valid    = (state_q == ST_RESP);
  assign rx_fire     = rx_valid && rx_ready;
  assign tx_fire     = tx_valid && tx_ready;
  assign rx_clr      = rx_fire && (state_q == ST_IDLE);
  assign addr_shift  = rx_fire && (state_q == ST_ADDR);
  assign data_shift  = rx_fire && (state_q == ST_DATA);
  assign sel_i       = op_is_icache(op_q);
  assign exec_active = (state_q == ST_EXEC);
  assign port_active = exec_active || (state_q == ST_RD_WAIT);
  assign tx_load     = (state_q == ST_RD_WAIT) && (wait_q == RL_LAST);
  assign tx_adv      = tx_fire && resp_multi_q;
  assign tx_word_in  = sel_i ? dbg_i_rd2 : dbg_d_rd2;

  byte_shift_le u_rx_addr (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .clr_i   (rx_clr),
    .load_i  (1'b0),
    .shift_i (addr_shift),
    .byte_i  (rx_data),
    .word_i  ('0),
    .word_o  (addr_word),
    .byte_o  (unused_addr_byte),
    .last_o  (addr_last)
  );

  byte_shift_le u_rx_data (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .clr_i   (rx_clr),
    .load_i  (1'b0),
    .shift_i (data_shift),
    .byte_i  (rx_data),
    .word_i  ('0),
    .word_o  (data_word),
    .byte_o  (unused_data_byte),
    .last_o  (data_last)
  );

  byte_shift_le u_tx_data (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .clr_i   (1'b0),
    .load_i  (tx_load),
    .shift_i (tx_adv),
    .byte_i  (8'h00),
    .word_i  (tx_word_in),
    .word_o  (unused_tx_word),
    .byte_o  (tx_byte),
    .last_o  (tx_last)
  );

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    resp_byte_d  = resp_byte_q;
    resp_multi_d = resp_multi_q;
    cpu_rst_d    = cpu_rst_q;
    wait_d       = wait_q;
    i_a2_d       = i_a2_q;
    i_wd2_d      = i_wd2_q;
    d_a2_d       = d_a2_q;
    d_wd2_d      = d_wd2_q;

    case (state_q)
      ST_IDLE: begin
        if (rx_fire) begin
          op_d = rx_data;
          case (rx_data)
            OP_WR_I, OP_WR_D, OP_RD_I, OP_RD_D: state_d = ST_ADDR;
            OP_RUN, OP_HALT:                    state_d = ST_CTRL;
            default: begin
              resp_byte_d  = ERR_BYTE;
              resp_multi_d = 1'b0;
              state_d      = ST_RESP;
            end
          endcase
        end
      end
      ST_ADDR: begin
        if (rx_fire && addr_last) begin
          wait_d  = '0;
          state_d = op_is_write(op_q) ? ST_DATA : ST_RD_WAIT;
        end
      end
      ST_DATA: begin
        if (rx_fire && data_last) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        resp_byte_d  = ACK_BYTE;
        resp_multi_d = 1'b0;
        state_d      = ST_RESP;
      end
      ST_RD_WAIT: begin
        if (wait_q == RL_LAST) begin
          resp_multi_d = 1'b1;
          state_d      = ST_RESP;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      ST_CTRL: begin
        cpu_rst_d    = (op_q == OP_HALT);
        resp_byte_d  = ACK_BYTE;
        resp_multi_d = 1'b0;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        if (tx_fire && (!resp_multi_q || tx_last)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Port address/data are driven straight from the assembly registers while
    // active; the _q copies only remember them so the ports hold afterwards.
    if (port_active) begin
      if (sel_i) i_a2_d = addr_word;
      else       d_a2_d = addr_word;
    end
    if (exec_active) begin
      if (sel_i) i_wd2_d = data_word;
      else       d_wd2_d = data_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      op_q         <= '0;
      resp_byte_q  <= '0;
      resp_multi_q <= 1'b0;
      cpu_rst_q    <= 1'b1;
      wait_q       <= '0;
      i_a2_q       <= '0;
      i_wd2_q      <= '0;
      d_a2_q       <= '0;
      d_wd2_q      <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      resp_byte_q  <= resp_byte_d;
      resp_multi_q <= resp_multi_d;
      cpu_rst_q    <= cpu_rst_d;
      wait_q       <= wait_d;
      i_a2_q       <= i_a2_d;
      i_wd2_q      <= i_wd2_d;
      d_a2_q       <= d_a2_d;
      d_wd2_q      <= d_wd2_d;
    end
  end

  assign dbg_i_a2  = (port_active && sel_i)  ? addr_word : i_a2_q;
  assign dbg_i_wd2 = (exec_active && sel_i)  ? data_word : i_wd2_q;
  assign dbg_i_we2 = (exec_active && sel_i)  ? '1 : '0;
  assign dbg_d_a2  = (port_active && !sel_i) ? addr_word : d_a2_q;
  assign dbg_d_wd2 = (exec_active && !sel_i) ? data_word : d_wd2_q;
  assign dbg_d_we2 = (exec_active && !sel_i) ? '1 : '0;

  assign tx_data = resp_multi_q ? tx_byte : resp_byte_q;
  assign cpu_rst = cpu_rst_q;
  assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dbg_mem_loader.sv
module tb_dbg_mem_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] dbg_i_a2, dbg_i_wd2, dbg_i_rd2;
  logic [31:0] dbg_d_a2, dbg_d_wd2, dbg_d_rd2;
  logic [3:0]  dbg_i_we2, dbg_d_we2;
  logic        cpu_rst, busy;

  typedef struct {
    logic        port_d;
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [31:0] ref_i [logic [29:0]];
  logic [31:0] ref_d [logic [29:0]];
  logic [31:0] ram_i [logic [29:0]];
  logic [31:0] ram_d [logic [29:0]];
  logic [7:0]  exp_tx[$];
  wr_t         exp_wr[$];
  logic [7:0]  tx_log[$];
  logic [7:0]  cmd[$];
  logic        model_cpu_rst = 1'b1;
  int unsigned i_we_cycles = 0;
  int unsigned d_we_cycles = 0;
  logic [31:0] last_i_a2 = '0;
  logic [31:0] last_i_wd2 = '0;
  int          tx_mode = 2;   // 0 random, 1 stalled, 2 always ready

  dbg_mem_loader #(
    .READ_LATENCY (1),
    .ACK_BYTE     (8'hAA),
    .ERR_BYTE     (8'hEE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .dbg_i_a2  (dbg_i_a2),
    .dbg_i_wd2 (dbg_i_wd2),
    .dbg_i_we2 (dbg_i_we2),
    .dbg_i_rd2 (dbg_i_rd2),
    .dbg_d_a2  (dbg_d_a2),
    .dbg_d_wd2 (dbg_d_wd2),
    .dbg_d_we2 (dbg_d_we2),
    .dbg_d_rd2 (dbg_d_rd2),
    .cpu_rst   (cpu_rst),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
    end
  endfunction

  function automatic void fail(input string nm, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s actual=%h required=nothing t=%0t", nm, act, $time);
  endfunction

  function automatic logic [31:0] ref_rd(input logic port_d, input logic [31:0] a);
    if (port_d) return ref_d.exists(a[31:2]) ? ref_d[a[31:2]] : '0;
    return ref_i.exists(a[31:2]) ? ref_i[a[31:2]] : '0;
  endfunction

  // Reference behaviour of one whole command, applied to the model state.
  function automatic void model_cmd();
    logic [7:0]  op;
    logic [31:0] a, d, w;
    op = cmd[0];
    if (op >= 8'h01 && op <= 8'h04) a = {cmd[4], cmd[3], cmd[2], cmd[1]};
    else a = '0;
    case (op)
      8'h01, 8'h02: begin
        d = {cmd[8], cmd[7], cmd[6], cmd[5]};
        exp_wr.push_back('{port_d: (op == 8'h02), a: a, d: d});
        if (op == 8'h02) ref_d[a[31:2]] = d;
        else             ref_i[a[31:2]] = d;
        exp_tx.push_back(8'hAA);
      end
      8'h03, 8'h04: begin
        w = ref_rd(op == 8'h04, a);
        for (int k = 0; k < 4; k++) exp_tx.push_back(w[8*k +: 8]);
      end
      8'h05: begin model_cpu_rst = 1'b0; exp_tx.push_back(8'hAA); end
      8'h06: begin model_cpu_rst = 1'b1; exp_tx.push_back(8'hAA); end
      default: exp_tx.push_back(8'hEE);
    endcase
  endfunction

  function automatic void add32(input logic [31:0] w);
    for (int k = 0; k < 4; k++) cmd.push_back(w[8*k +: 8]);
  endfunction

  // Behavioural 1-cycle-latency synchronous cache RAMs.
  initial begin
    dbg_i_rd2 = '0;
    dbg_d_rd2 = '0;
    forever begin
      @(posedge clk);
      dbg_i_rd2 <= ram_i.exists(dbg_i_a2[31:2]) ? ram_i[dbg_i_a2[31:2]] : '0;
      dbg_d_rd2 <= ram_d.exists(dbg_d_a2[31:2]) ? ram_d[dbg_d_a2[31:2]] : '0;
      if (dbg_i_we2 == 4'hF) ram_i[dbg_i_a2[31:2]] = dbg_i_wd2;
      if (dbg_d_we2 == 4'hF) ram_d[dbg_d_a2[31:2]] = dbg_d_wd2;
    end
  end

  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (tx_mode == 0)      tx_ready = 1'($urandom_range(0, 1));
      else if (tx_mode == 1) tx_ready = 1'b0;
      else                   tx_ready = 1'b1;
    end
  end

  // Compare process: port writes, response bytes, handshake rules.
  initial begin
    logic       prev_valid, prev_ready;
    logic [7:0] prev_data;
    wr_t        w;
    prev_valid = 1'b0;
    prev_ready = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_valid = 1'b0;
      end else begin
        if (dbg_i_we2 != 4'h0) begin
          i_we_cycles++;
          last_i_a2  = dbg_i_a2;
          last_i_wd2 = dbg_i_wd2;
        end
        if (dbg_d_we2 != 4'h0) d_we_cycles++;
        if (dbg_i_we2 != 4'h0 || dbg_d_we2 != 4'h0) begin
          if (exp_wr.size() == 0) begin
            fail("unexpected_we2", {24'h0, dbg_i_we2, dbg_d_we2});
          end else begin
            w = exp_wr.pop_front();
            if (w.port_d) begin
              chk("d_we2", 32'(dbg_d_we2), 32'hF);
              chk("i_we2_idle", 32'(dbg_i_we2), 32'h0);
              chk("d_a2", dbg_d_a2, w.a);
              chk("d_wd2", dbg_d_wd2, w.d);
            end else begin
              chk("i_we2", 32'(dbg_i_we2), 32'hF);
              chk("d_we2_idle", 32'(dbg_d_we2), 32'h0);
              chk("i_a2", dbg_i_a2, w.a);
              chk("i_wd2", dbg_i_wd2, w.d);
            end
          end
        end
        if (tx_valid) chk("rx_ready_in_resp", 32'(rx_ready), 32'h0);
        if (prev_valid && !prev_ready) begin
          chk("tx_valid_held", 32'(tx_valid), 32'h1);
          chk("tx_data_stable", 32'(tx_data), 32'(prev_data));
        end
        if (tx_valid && tx_ready) begin
          tx_log.push_back(tx_data);
          if (exp_tx.size() == 0) fail("unexpected_tx", 32'(tx_data));
          else chk("tx_byte", 32'(tx_data), 32'(exp_tx.pop_front()));
        end
        prev_valid = tx_valid;
        prev_ready = tx_ready;
        prev_data  = tx_data;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    @(posedge clk);
    #1;
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (rx_ready) break;
      n++;
      if (n > 300) begin
        fail("rx_accept_timeout", 32'(b));
        break;
      end
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    if (tx_mode == 0) repeat ($urandom_range(0, 2)) @(posedge clk);
  endtask

  task automatic send_cmd_bytes();
    if (cmd[0] >= 8'h01 && cmd[0] <= 8'h06) begin
      foreach (cmd[k]) send_byte(cmd[k]);
    end else begin
      send_byte(cmd[0]);
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (exp_tx.size() == 0 && !busy) break;
      n++;
      if (n > 1000) begin
        fail("cmd_done_timeout", 32'(exp_tx.size()));
        exp_tx.delete();
        exp_wr.delete();
        break;
      end
    end
    chk("writes_drained", 32'(exp_wr.size()), 32'h0);
    chk("cpu_rst", 32'(cpu_rst), 32'(model_cpu_rst));
  endtask

  task automatic run_cmd();
    model_cmd();
    send_cmd_bytes();
    wait_done();
  endtask

  initial begin
    int unsigned i0, d0, n, r;
    logic [7:0]  held, op;
    logic [31:0] a;

    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = '0;
    repeat (3) @(negedge clk);
    chk("rst_cpu_rst", 32'(cpu_rst), 32'h1);
    chk("rst_tx_valid", 32'(tx_valid), 32'h0);
    chk("rst_tx_data", 32'(tx_data), 32'h0);
    chk("rst_rx_ready", 32'(rx_ready), 32'h1);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_we2", {24'h0, dbg_i_we2, dbg_d_we2}, 32'h0);
    chk("rst_i_a2", dbg_i_a2, 32'h0);
    chk("rst_d_wd2", dbg_d_wd2, 32'h0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Release core.
    tx_log.delete();
    cmd = {8'h05};
    run_cmd();
    chk("run_ack_len", 32'(tx_log.size()), 32'h1);
    if (tx_log.size() > 0) chk("run_ack_literal", 32'(tx_log[0]), 32'hAA);
    chk("run_cpu_rst_literal", 32'(cpu_rst), 32'h0);

    // I-cache word write.
    i0 = i_we_cycles; d0 = d_we_cycles;
    tx_log.delete();
    cmd = {8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
    run_cmd();
    chk("wr_i_we_cycles", i_we_cycles - i0, 32'h1);
    chk("wr_i_no_d_we", d_we_cycles - d0, 32'h0);
    chk("wr_i_a2_literal", last_i_a2, 32'h0);
    chk("wr_i_wd2_literal", last_i_wd2, 32'h0000_0013);
    if (tx_log.size() > 0) chk("wr_i_ack_literal", 32'(tx_log[0]), 32'hAA);

    // D-cache write then read back.
    cmd = {8'h02, 8'h10, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_cmd();
    tx_log.delete();
    cmd = {8'h04, 8'h10, 8'h00, 8'h00, 8'h00};
    run_cmd();
    chk("rd_d_len", 32'(tx_log.size()), 32'h4);
    if (tx_log.size() == 4) begin
      chk("rd_d_b0", 32'(tx_log[0]), 32'hEF);
      chk("rd_d_b1", 32'(tx_log[1]), 32'hBE);
      chk("rd_d_b2", 32'(tx_log[2]), 32'hAD);
      chk("rd_d_b3", 32'(tx_log[3]), 32'hDE);
    end

    // Unknown opcode, then a normal command.
    i0 = i_we_cycles; d0 = d_we_cycles;
    tx_log.delete();
    cmd = {8'h7F};
    run_cmd();
    chk("err_len", 32'(tx_log.size()), 32'h1);
    if (tx_log.size() > 0) chk("err_literal", 32'(tx_log[0]), 32'hEE);
    chk("err_no_we", (i_we_cycles - i0) + (d_we_cycles - d0), 32'h0);
    cmd = {8'h06};
    run_cmd();
    chk("halt_cpu_rst_literal", 32'(cpu_rst), 32'h1);

    // Stalled response.
    cmd = {8'h02, 8'h20, 8'h00, 8'h00, 8'h00};
    add32(32'hC3B2_A190);
    run_cmd();
    tx_mode = 1;
    cmd = {8'h04, 8'h20, 8'h00, 8'h00, 8'h00};
    model_cmd();
    send_cmd_bytes();
    n = 0;
    while (!tx_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("stall_tx_valid", 32'(tx_valid), 32'h1);
    held = tx_data;
    chk("stall_byte0_literal", 32'(held), 32'h90);
    rx_data  = 8'h01;
    rx_valid = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk("stall_tx_data", 32'(tx_data), 32'(held));
      chk("stall_rx_ready", 32'(rx_ready), 32'h0);
    end
    rx_valid = 1'b0;
    tx_mode  = 2;
    wait_done();

    // Reset in the middle of a write command.
    cmd = {8'h05};
    run_cmd();
    i0 = i_we_cycles; d0 = d_we_cycles;
    send_byte(8'h01);
    send_byte(8'h40); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h11);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    model_cpu_rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_cpu_rst", 32'(cpu_rst), 32'h1);
    chk("mid_rst_rx_ready", 32'(rx_ready), 32'h1);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    chk("mid_rst_no_we", (i_we_cycles - i0) + (d_we_cycles - d0), 32'h0);
    cmd = {8'h03, 8'h40, 8'h00, 8'h00, 8'h00};
    run_cmd();
    cmd = {8'h01, 8'h40, 8'h00, 8'h00, 8'h00};
    add32(32'h1234_5678);
    run_cmd();
    cmd = {8'h03, 8'h40, 8'h00, 8'h00, 8'h00};
    run_cmd();

    // Randomized command stream with random host back-pressure.
    tx_mode = 0;
    repeat (80) begin
      r = $urandom_range(0, 7);
      a = (32'($urandom_range(0, 1)) << 31) | (32'($urandom_range(0, 15)) << 2)
        | 32'($urandom_range(0, 3));
      case (r)
        0, 1: op = 8'h01;
        2, 3: op = 8'h02;
        4:    op = 8'h03;
        5:    op = 8'h04;
        6:    op = ($urandom_range(0, 1) != 0) ? 8'h05 : 8'h06;
        default: op = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(7, 255));
      endcase
      cmd = {op};
      if (op >= 8'h01 && op <= 8'h04) add32(a);
      if (op == 8'h01 || op == 8'h02) add32($urandom);
      run_cmd();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dbg_mem_loader.md
Name: dbg_mem_loader

Overview:
Host-side initiator for the core's debug cache ports (the A2/WD2/WE2/RD2 port pairs on the instruction and data caches).
- Accepts a byte-stream command protocol from a host link, such as a UART receiver.
- Writes and reads words through the debug ports.
- Returns read data or status bytes on an outbound byte stream.
- Owns the core's CPU_RST so the program image can be loaded while the core is held in reset.
- Sits beside the core at SoC top level; drives the core's debug inputs and consumes its debug outputs.

Parameters:
READ_LATENCY, 1, cycles from stable debug address to valid RD2 (synchronous cache read); legal range 1..3.
ACK_BYTE, 8'hAA, response byte for a completed write or CPU control command.
ERR_BYTE, 8'hEE, response byte for an unknown opcode.

Ports:
clk  in  1  single clock, shared with CPU_CLK.
rst_n  in  1  asynchronous active-low reset.
rx_data  in  8  command byte from host.
rx_valid  in  1  rx_data valid.
rx_ready  out  1  block accepts rx_data this cycle.
tx_data  out  8  response byte to host.
tx_valid  out  1  tx_data valid.
tx_ready  in  1  host accepts tx_data this cycle.
dbg_i_a2  out  32  instruction-cache debug address.
dbg_i_wd2  out  32  instruction-cache debug write data.
dbg_i_we2  out  4  instruction-cache debug byte write enables.
dbg_i_rd2  in  32  instruction-cache debug read data.
dbg_d_a2  out  32  data-cache debug address.
dbg_d_wd2  out  32  data-cache debug write data.
dbg_d_we2  out  4  data-cache debug byte write enables.
dbg_d_rd2  in  32  data-cache debug read data.
cpu_rst  out  1  active-high reset to the core's CPU_RST.
busy  out  1  high whenever state != IDLE.

Behaviour:
Reset (rst_n low, asynchronous):
- State = IDLE; all counters = 0.
- rx_ready = 1, tx_valid = 0, tx_data = 0.
- Both a2, wd2 and we2 outputs = 0.
- cpu_rst = 1, i.e. the core is held after power-up.
- A reset taken mid-command aborts the command with no partial write.

Handshakes:
- An rx byte transfers only when rx_valid && rx_ready.
- A tx byte transfers only when tx_valid && tx_ready.
- tx_data is stable while tx_valid is high and not yet accepted.

Commands (first byte is the opcode; multi-byte fields are little-endian):
- 0x01: write I-cache. 4 address bytes, 4 data bytes; response ACK_BYTE.
- 0x02: write D-cache. Same format as 0x01; response ACK_BYTE.
- 0x03: read I-cache. 4 address bytes; response 4 data bytes, LSB first.
- 0x04: read D-cache. Same format as 0x03.
- 0x05: release core. cpu_rst <= 0; response ACK_BYTE.
- 0x06: hold core. cpu_rst <= 1; response ACK_BYTE.
- Any other opcode: response ERR_BYTE, no further bytes consumed, no port activity.

FSM:
- IDLE: rx_ready = 1. An accepted byte latches the opcode and goes to ADDR (0x01–0x04), CTRL (0x05/0x06), or RESP with ERR_BYTE (other).
- ADDR: collects 4 bytes into addr[31:0], byte k filling bits [8k+7:8k]. After the 4th byte go to DATA for writes, RD_WAIT for reads.
- DATA: collects 4 bytes into wdata, then goes to EXEC.
- EXEC: exactly one cycle. The selected port drives a2 = addr, wd2 = wdata, we2 = 4'b1111; the other port's we2 stays 0. Then go to RESP with ACK_BYTE.
- RD_WAIT: the selected a2 holds addr for READ_LATENCY+1 cycles. RD2 is sampled into rdata on the last of these cycles. Then go to RESP with 4 bytes.
- CTRL: updates cpu_rst, then goes to RESP with ACK_BYTE.
- RESP: tx_valid = 1; the byte index advances on each accepted byte. After the last byte, tx_valid = 0 and the state returns to IDLE.

Port and timing rules:
- rx_ready = 0 in every state except IDLE, ADDR and DATA.
- a2 and wd2 hold their last values outside EXEC/RD_WAIT; we2 is 0 outside EXEC.
- a2 carries the raw address; bits [1:0] are passed unmodified because the caches index on [31:2].
- Debug accesses are legal while cpu_rst = 0. Coherence with concurrent core accesses is the host's responsibility.
- A stalled tx_ready holds RESP indefinitely; no rx bytes are accepted meanwhile.
- Minimum write-command latency: 9 rx bytes, then 1 EXEC cycle, then the ACK is offered on the next cycle.

Decomposition:
- Shared package `dbg_loader_pkg`:
  - opcode localparams (OP_WR_I, OP_WR_D, OP_RD_I, OP_RD_D, OP_RUN, OP_HALT);
  - state enum;
  - ACK/ERR default constants.
- One sub-module, `byte_shift_le`: a 4-byte little-endian assemble/serialise register with a 2-bit index counter, instantiated for rx address/data and for tx read data.

Test Plan:
1. Reset release → cpu_rst = 1, tx_valid = 0, all we2 = 0; send 0x05 → tx byte 0xAA, then cpu_rst = 0.
2. Send 01, 00 00 00 00, 13 00 00 00 → exactly one cycle with dbg_i_we2 = 4'hF, dbg_i_a2 = 0, dbg_i_wd2 = 32'h00000013; dbg_d_we2 never asserted; response 0xAA.
3. Send 02, 10 00 00 00, EF BE AD DE, then 04, 10 00 00 00, with a behavioural 1-cycle-latency RAM → tx bytes EF, BE, AD, DE in order.
4. Opcode 0x7F → single tx byte 0xEE, no we2 activity, next command accepted normally.
5. Hold tx_ready = 0 for 20 cycles during a read response → tx_data stable at byte 0, rx_ready = 0 throughout, no byte lost after release.
6. Pulse rst_n low after 6 bytes of a write command → no we2 pulse, state IDLE, cpu_rst = 1, and the following full command completes.
